scalar_reg_host_port: RTL
=========================

Name: scalar_reg_host_port

Overview:
- Host-side initiator for the scalar register file. It accepts read/write requests over a valid/ready channel and buffers them in a small FIFO.
- It drives the register file's single write port and combinational read port, one command at a time, and returns one response per request over a second valid/ready channel.
- Sits between the Caravel host/wishbone bridge and the scalar register file inside the vector coprocessor.

Parameters:
- REG_DEPTH, 6, number of implemented scalar registers; valid addresses are 0..REG_DEPTH-1
- REG_WIDTH, 32, data width
- ADDR_WIDTH, 5, address width
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request FIFO can accept
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  register address
- req_wdata  in  REG_WIDTH  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  REG_WIDTH  read data; 0 for writes
- rsp_err  out  1  address out of range (or verify mismatch)
- busy  out  1  FIFO non-empty or FSM not IDLE
- rf_read_address  out  ADDR_WIDTH  to register file read_address
- rf_write_address  out  ADDR_WIDTH  to register file write_address
- rf_write_data  out  REG_WIDTH  to register file write_data
- rf_write_enable  out  1  to register file write_enable
- rf_read_data  in  REG_WIDTH  from register file read_data (combinational)

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values:
  - FIFO empty; state IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - rf_write_enable=0; rf addresses and rf_write_data 0.
  - req_ready=1 once reset_n deasserts.
- Reset mid-operation aborts everything: in-flight command and queued entries are dropped, and no write is issued.
- Request handshake:
  - A push occurs when req_valid && req_ready.
  - req_ready = !full. When full, no push is taken even if a pop happens the same cycle.
  - The master must hold req_* stable while valid and not ready.
- FIFO: registered storage with pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection; pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the command register (write, addr, wdata), then go to EXEC. Otherwise stay.
  - EXEC (exactly 1 cycle):
    - rf_read_address and rf_write_address = cmd addr; rf_write_data = cmd wdata.
    - If write and addr<REG_DEPTH: rf_write_enable=1 for this cycle only.
    - If read and addr<REG_DEPTH: capture rf_read_data into rsp_rdata.
    - If addr>=REG_DEPTH: no write, rsp_rdata=0, rsp_err=1.
    - Next state is RESP (or VERIFY, see Optional Feature).
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable. On rsp_ready, clear rsp_valid and go to IDLE.
- rf_write_enable is never asserted outside EXEC.
- rf address outputs hold their last command value in other states.
- Minimum latency: push at cycle N, pop at N+1, EXEC at N+2, rsp_valid at N+3.
- Back-to-back commands: one command per 3 cycles when rsp_ready is held high.
- rsp_valid drops no earlier than the cycle after the rsp_ready handshake.
- Requests keep being accepted while the FSM stalls in RESP, until the FIFO is full.
- Responses return in request order.
- busy = !empty || state!=IDLE.

Optional Feature:
- Macro: SRF_READBACK_VERIFY_EN.
- Defined:
  - An in-range write goes EXEC -> VERIFY -> RESP.
  - In VERIFY, rf_read_address = cmd addr and rf_read_data is compared with cmd wdata. A mismatch sets rsp_err=1; rsp_rdata stays 0.
  - Write latency grows by 1 cycle.
  - Reads and out-of-range commands skip VERIFY.
- Undefined: VERIFY state is absent; timing is as in Behaviour.

Test Plan:
- Reset, then write addr 3 data 0xDEADBEEF with rsp_ready=1 -> rf_write_enable high exactly 1 cycle with address 3; rsp_valid 3 cycles after the push, rsp_err=0, rsp_rdata=0. A subsequent read of addr 3 returns 0xDEADBEEF.
- Read addr 7 (REG_DEPTH=6) -> no rf_write_enable; rsp_err=1, rsp_rdata=0.
- Hold rsp_ready=0 and push 6 reads -> 1 command stalls in RESP and 4 sit in the FIFO; req_ready=0 when the FIFO is full. Release rsp_ready -> 5 responses in order, then the remaining request is accepted and answered.
- Assert reset_n=0 during EXEC of a write to addr 2 with data 0x55 -> no write completes; rsp_valid=0, FIFO empty, busy=0; a read of addr 2 after reset returns the register file reset value 0.
- Alternating write/read to addresses 0..5 with random rsp_ready backpressure -> every read matches the last written data; the response count equals the request count.
- With SRF_READBACK_VERIFY_EN, a bench model corrupts rf_read_data for addr 1 -> the write response has rsp_err=1 and write latency is 4 cycles.

Source files
------------

// File: rtl/scalar_reg_host_port.sv
// scalar_reg_host_port
// Host-side initiator for the scalar register file. Requests arrive on a
// valid/ready channel, wait in a small FIFO, and are executed one at a time
// against the register file's single write port and combinational read port.
// Each request gets exactly one response, returned in request order.
//
// Optional build macro: SRF_READBACK_VERIFY_EN
//   When defined, every in-range write reads its register back one cycle
//   later (VERIFY state) and flags rsp_err if the data does not match.
module scalar_reg_host_port #(
  parameter int REG_DEPTH  = 6,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rf_read_address,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [REG_WIDTH-1:0]  rf_write_data,
  output logic                  rf_write_enable,
  input  logic [REG_WIDTH-1:0]  rf_read_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  // One extra bit so an address equal to REG_DEPTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(REG_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESP   = 2'd2
`ifdef SRF_READBACK_VERIFY_EN
    , VERIFY = 2'd3
`endif
  } state_t;

  state_t state, next_state;

  // Request FIFO storage and pointers (extra MSB distinguishes full from empty).
  logic                  fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [REG_WIDTH-1:0]  fifo_wdata [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Command currently being executed.
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [REG_WIDTH-1:0]  cmd_wdata;
  logic                  cmd_in_range;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign req_ready = !full;
  assign push      = req_valid && !full;

  assign cmd_in_range = ({1'b0, cmd_addr} < DEPTH_LIMIT);

  // The register file sees the command register directly, so its addresses
  // hold the last command's value outside EXEC/VERIFY.
  assign rf_read_address  = cmd_addr;
  assign rf_write_address = cmd_addr;
  assign rf_write_data    = cmd_wdata;
  assign rf_write_enable  = (state == EXEC) && cmd_write && cmd_in_range;

  assign rsp_valid = (state == RESP);
  assign busy      = !empty || (state != IDLE);

  // Capture an accepted request into the FIFO slot the write pointer names.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr[PTR_W-1:0]] <= req_write;
      fifo_addr[wr_ptr[PTR_W-1:0]]  <= req_addr;
      fifo_wdata[wr_ptr[PTR_W-1:0]] <= req_wdata;
    end
  end

  // Advance FIFO pointers on push and pop; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // State register; reset drops any in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: pop in IDLE, one EXEC cycle, then hold RESP until taken.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
`ifdef SRF_READBACK_VERIFY_EN
        if (cmd_write && cmd_in_range) begin
          next_state = VERIFY;
        end
`endif
      end
`ifdef SRF_READBACK_VERIFY_EN
      VERIFY: begin
        next_state = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Load the command register on pop and build the response during EXEC/VERIFY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) begin
        cmd_write <= fifo_write[rd_ptr[PTR_W-1:0]];
        cmd_addr  <= fifo_addr[rd_ptr[PTR_W-1:0]];
        cmd_wdata <= fifo_wdata[rd_ptr[PTR_W-1:0]];
      end
      if (state == EXEC) begin
        if (!cmd_in_range) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else if (cmd_write) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= rf_read_data;
          rsp_err   <= 1'b0;
        end
      end
`ifdef SRF_READBACK_VERIFY_EN
      if (state == VERIFY) begin
        rsp_err <= (rf_read_data != cmd_wdata);
      end
`endif
    end
  end

endmodule
